// File: rtl/alu_nbit_seq_if.sv
// Handshake bundle between the EX-stage control and the sequential ALU.
// The control side drives start/op/operands; the ALU returns result and status.
interface alu_nbit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, alu_op, a, b,
        input  result, zero, overflow, busy, done
    );

    modport slave (
        input  start, alu_op, a, b,
        output result, zero, overflow, busy, done
    );
endinterface

// File: rtl/alu_nbit_seq.sv
// WIDTH-bit ALU with single-cycle logic/arithmetic ops and a
// restoring shift-subtract MOD engine behind a start/busy/done handshake.
module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    alu_nbit_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] res;
    logic             zero_flag;
    logic             ovf_flag;
    logic             done_pulse;

    logic             accept;
    logic             mod_run;
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             carry_msb;
    logic             ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_next;

    assign accept  = bus.start && (state == IDLE);
    assign mod_run = (bus.alu_op == OP_MOD) && (bus.b != '0);

    // Single-cycle datapath: shared adder for ADD/SUB/SLT plus logic ops
    always_comb begin
        sub_op  = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
        b_eff   = sub_op ? ~bus.b : bus.b;
        {carry_out, sum} = {1'b0, bus.a} + {1'b0, b_eff}
                         + {{WIDTH{1'b0}}, sub_op};
        carry_msb = bus.a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
        ovf       = carry_msb ^ carry_out;
        alu_res   = '0;
        alu_ovf   = 1'b0;
        unique case (bus.alu_op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOR: alu_res = ~(bus.a | bus.b);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = ovf;
            end
            OP_SUB: begin
                alu_res = sum;
                alu_ovf = ovf;
            end
            // Only reached as a 1-cycle op when b==0: pass a through
            OP_MOD: alu_res = bus.a;
            default: alu_res = '0;
        endcase
    end

    // One restoring-remainder step; rem is widened by one bit for the compare
    always_comb begin
        rem_sh  = {rem, dividend[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - divisor;
        if (rem_sh >= {1'b0, divisor}) begin
            rem_next = rem_sub;
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter RUN on a real MOD, leave after the last iteration
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && mod_run) state_next = RUN;
            RUN:  if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, MOD iteration and registered result/flags
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend   <= '0;
            divisor    <= '0;
            rem        <= '0;
            cnt        <= '0;
            res        <= '0;
            zero_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (accept) begin
                if (mod_run) begin
                    rem      <= '0;
                    dividend <= bus.a;
                    divisor  <= bus.b;
                    cnt      <= CW'(WIDTH-1);
                end else begin
                    res        <= alu_res;
                    zero_flag  <= (alu_res == '0);
                    ovf_flag   <= alu_ovf;
                    done_pulse <= 1'b1;
                end
            end else if (state == RUN) begin
                rem      <= rem_next;
                dividend <= {dividend[WIDTH-2:0], 1'b0};
                cnt      <= cnt - 1'b1;
                if (cnt == '0) begin
                    res        <= rem_next;
                    zero_flag  <= (rem_next == '0);
                    ovf_flag   <= 1'b0;
                    done_pulse <= 1'b1;
                end
            end
        end
    end

    assign bus.result   = res;
    assign bus.zero     = zero_flag;
    assign bus.overflow = ovf_flag;
    assign bus.done     = done_pulse;
    assign bus.busy     = (state == RUN);
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed self-checking bench for alu_nbit_seq.
// Exercises 32-bit and 8-bit instances through the handshake interface.
module tb_alu_nbit_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_nbit_seq_if #(.WIDTH(32)) bus32();
    alu_nbit_seq_if #(.WIDTH(8))  bus8();

    alu_nbit_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus32.slave)
    );

    alu_nbit_seq #(.WIDTH(8)) dut8 (
        .clk(clk),
        .reset(reset),
        .bus(bus8.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus32.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus32.result); end
        checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", bus32.busy, bus32.done); end
        checks++; if (bus32.zero !== 1'b0 || bus32.overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus32.zero, bus32.overflow); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_mod;
        int ndone;
        bus32.alu_op = 3'b111; bus32.a = 32'd100; bus32.b = 32'd7;
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus32.busy !== 1'b1) begin failures++; $display("FAIL t1_busy_before got=%b exp=1", bus32.busy); end
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin failures++; $display("FAIL t1_busy_done got=%b%b exp=00", bus32.busy, bus32.done); end
        checks++; if (bus32.result !== 32'h0) begin failures++; $display("FAIL t1_result got=%h exp=0", bus32.result); end
        checks++; if (bus32.zero !== 1'b0 || bus32.overflow !== 1'b0) begin failures++; $display("FAIL t1_flags got=%b%b exp=00", bus32.zero, bus32.overflow); end
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.done === 1'b1 || bus32.busy === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL t1_stray got=%0d exp=0", ndone); end
    endtask

    task automatic test_logic;
        logic [31:0] exp_l [4];
        exp_l[0] = 32'h00F0000F;
        exp_l[1] = 32'hFFF00FFF;
        exp_l[2] = 32'hFF000FF0;
        exp_l[3] = 32'h000FF000;
        bus32.a = 32'hF0F0_00FF;
        bus32.b = 32'h0FF0_0F0F;
        bus32.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.alu_op = 3'(i);
            tick();
            checks++; if (bus32.result !== exp_l[i]) begin failures++; $display("FAIL t2_op%0d got=%h exp=%h", i, bus32.result, exp_l[i]); end
            checks++; if (bus32.done !== 1'b1) begin failures++; $display("FAIL t2_done%0d got=%b exp=1", i, bus32.done); end
        end
        bus32.start = 1'b0;
        tick();
        checks++; if (bus32.done !== 1'b0) begin failures++; $display("FAIL t2_done_end got=%b exp=0", bus32.done); end
    endtask

    task automatic test_arith;
        logic [2:0]  op [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] er [4];
        logic [1:0]  ef [4];
        op[0] = 3'b101; va[0] = 32'h7FFFFFFF; vb[0] = 32'h1;        er[0] = 32'h80000000; ef[0] = 2'b01;
        op[1] = 3'b110; va[1] = 32'd5;        vb[1] = 32'd5;        er[1] = 32'h0;        ef[1] = 2'b10;
        op[2] = 3'b100; va[2] = 32'hFFFFFFFF; vb[2] = 32'h1;        er[2] = 32'h1;        ef[2] = 2'b00;
        op[3] = 3'b100; va[3] = 32'h7FFFFFFF; vb[3] = 32'h80000000; er[3] = 32'h0;        ef[3] = 2'b10;
        bus32.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus32.alu_op = op[i]; bus32.a = va[i]; bus32.b = vb[i];
            tick();
            checks++; if (bus32.result !== er[i]) begin failures++; $display("FAIL t3_res%0d got=%h exp=%h", i, bus32.result, er[i]); end
            checks++; if ({bus32.zero, bus32.overflow} !== ef[i]) begin failures++; $display("FAIL t3_flags%0d got=%b%b exp=%b", i, bus32.zero, bus32.overflow, ef[i]); end
        end
        bus32.start = 1'b0;
        tick();
    endtask

    task automatic test_mod;
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] er [2];
        int lat;
        va[0] = 32'd100;      vb[0] = 32'd7;  er[0] = 32'd2;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'h10; er[1] = 32'hF;
        for (int k = 0; k < 2; k++) begin
            bus32.alu_op = 3'b111; bus32.a = va[k]; bus32.b = vb[k];
            bus32.start = 1'b1;
            tick();
            bus32.start = 1'b0;
            checks++; if (bus32.busy !== 1'b1 || bus32.done !== 1'b0) begin failures++; $display("FAIL t4_accept%0d busy_done got=%b%b exp=10", k, bus32.busy, bus32.done); end
            lat = 0;
            while (bus32.done !== 1'b1 && lat < 100) begin
                if (k == 0 && lat == 10) begin
                    bus32.start = 1'b1; bus32.alu_op = 3'b000;
                    bus32.a = 32'h0; bus32.b = 32'h0;
                end else begin
                    bus32.start = 1'b0;
                end
                tick();
                lat++;
            end
            checks++; if (lat !== 32) begin failures++; $display("FAIL t4_latency%0d got=%0d exp=32", k, lat); end
            checks++; if (bus32.result !== er[k]) begin failures++; $display("FAIL t4_result%0d got=%h exp=%h", k, bus32.result, er[k]); end
            checks++; if (bus32.busy !== 1'b0 || bus32.overflow !== 1'b0) begin failures++; $display("FAIL t4_end%0d busy_ovf got=%b%b exp=00", k, bus32.busy, bus32.overflow); end
            tick();
        end
    endtask

    task automatic test_mod_zero;
        int lat;
        int saw_busy;
        bus32.alu_op = 3'b111; bus32.a = 32'd1234; bus32.b = 32'd0;
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        saw_busy = (bus32.busy === 1'b1) ? 1 : 0;
        checks++; if (bus32.done !== 1'b1 || bus32.result !== 32'd1234) begin failures++; $display("FAIL t5_div0 got=%b/%0d exp=1/1234", bus32.done, bus32.result); end
        checks++; if (bus32.overflow !== 1'b0) begin failures++; $display("FAIL t5_div0_ovf got=%b exp=0", bus32.overflow); end
        tick();
        if (bus32.busy === 1'b1) saw_busy++;
        checks++; if (saw_busy !== 0 || bus32.done !== 1'b0) begin failures++; $display("FAIL t5_div0_busy got=%0d/%b exp=0/0", saw_busy, bus32.done); end
        bus32.a = 32'd3; bus32.b = 32'd9;
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        lat = 0;
        while (bus32.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 32 || bus32.result !== 32'd3) begin failures++; $display("FAIL t5_3mod9 got=%0d/%0d exp=32/3", lat, bus32.result); end
        tick();
    endtask

    task automatic test_back_to_back;
        int lat;
        bus32.alu_op = 3'b111; bus32.a = 32'd100; bus32.b = 32'd7;
        bus32.start = 1'b1;
        tick();
        lat = 0;
        while (bus32.done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 32 || bus32.result !== 32'd2) begin failures++; $display("FAIL t6_mod got=%0d/%0d exp=32/2", lat, bus32.result); end
        bus32.alu_op = 3'b101; bus32.a = 32'd1; bus32.b = 32'd2;
        tick();
        checks++; if (bus32.done !== 1'b1 || bus32.result !== 32'd3) begin failures++; $display("FAIL t6_next got=%b/%0d exp=1/3", bus32.done, bus32.result); end
        checks++; if (bus32.busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%b exp=0", bus32.busy); end
        bus32.start = 1'b0;
        tick();
    endtask

    task automatic test_mod_w8;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [7:0] er [2];
        int lat;
        va[0] = 8'd100; vb[0] = 8'd7;    er[0] = 8'd2;
        va[1] = 8'hFF;  vb[1] = 8'h10;   er[1] = 8'hF;
        for (int k = 0; k < 2; k++) begin
            bus8.alu_op = 3'b111; bus8.a = va[k]; bus8.b = vb[k];
            bus8.start = 1'b1;
            tick();
            bus8.start = 1'b0;
            lat = 0;
            while (bus8.done !== 1'b1 && lat < 50) begin
                if (k == 0 && lat == 3) begin
                    bus8.start = 1'b1; bus8.alu_op = 3'b000;
                end else begin
                    bus8.start = 1'b0;
                end
                tick();
                lat++;
            end
            checks++; if (lat !== 8 || bus8.result !== er[k]) begin failures++; $display("FAIL t6_w8_mod%0d got=%0d/%h exp=8/%h", k, lat, bus8.result, er[k]); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus32.start = 1'b0; bus32.alu_op = 3'b000; bus32.a = '0; bus32.b = '0;
        bus8.start = 1'b0;  bus8.alu_op = 3'b000;  bus8.a = '0;  bus8.b = '0;
        test_reset();
        test_reset_mid_mod();
        test_logic();
        test_arith();
        test_mod();
        test_mod_zero();
        test_back_to_back();
        test_mod_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
